// File: rtl/game_input_pkg.sv
// Shared front-panel definitions: button indices, the idle event code and the
// index-to-event-code mapping used by the input queue and the game FSM.
package game_input_pkg;

  localparam int BTN_RIGHT      = 0;
  localparam int BTN_LEFT       = 1;
  localparam int BTN_DOWN       = 2;
  localparam int BTN_UP         = 3;
  localparam int BTN_DECISION   = 4;
  localparam int BTN_RESET_RED  = 5;
  localparam int BTN_RESET_BLUE = 6;

  localparam int CODE_IDLE = 0;

  // Code 0 stays reserved for "no event", so codes start at 1.
  function automatic int btn_code(input int idx);
    return idx + 1;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One push-button channel: two-flop synchroniser, counter debounce, press edge
// detection and an optional auto-repeat tick while the button is held.
module btn_conditioner #(
  parameter int DEBOUNCE      = 20,
  parameter bit REPEAT_EN     = 1'b0,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic evt
);

  localparam int DB_W    = $clog2(DEBOUNCE + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic             sync1;
  logic             sync2;
  logic [DB_W-1:0]  db_cnt;
  logic [DB_W-1:0]  db_nxt;
  logic             accept;
  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_nxt;
  logic [RPT_W-1:0] rpt_lim;
  logic             rpt_first;

  always_comb begin
    db_nxt  = db_cnt + DB_W'(1);
    accept  = (sync2 != level) && (db_nxt == DB_W'(DEBOUNCE));
    rpt_nxt = rpt_cnt + RPT_W'(1);
    rpt_lim = rpt_first ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_PERIOD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      db_cnt    <= '0;
      level     <= 1'b0;
      evt       <= 1'b0;
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      evt   <= 1'b0;

      if (sync2 == level) begin
        db_cnt <= '0;
      end else if (accept) begin
        db_cnt <= '0;
        level  <= sync2;
      end else begin
        db_cnt <= db_nxt;
      end

      // A release being accepted this cycle suppresses any coincident repeat tick.
      if (accept && sync2) begin
        evt       <= 1'b1;
        rpt_cnt   <= '0;
        rpt_first <= 1'b1;
      end else if (!level || accept) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b1;
      end else if (REPEAT_EN) begin
        if (rpt_nxt == rpt_lim) begin
          evt       <= 1'b1;
          rpt_cnt   <= '0;
          rpt_first <= 1'b0;
        end else begin
          rpt_cnt <= rpt_nxt;
        end
      end
    end
  end

endmodule

// File: rtl/button_event_queue.sv
// Front-panel input block: conditions every button, arbitrates pending events
// by priority (highest index first) and queues their codes in a small FIFO.
module button_event_queue #(
  parameter int               N_BTN         = 7,
  parameter int               CODE_W        = 3,
  parameter int               DEBOUNCE      = 20,
  parameter logic [N_BTN-1:0] REPEAT_MASK   = 7'b0001111,
  parameter int               REPEAT_DELAY  = 500,
  parameter int               REPEAT_PERIOD = 100,
  parameter int               FIFO_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BTN-1:0]  btn_in,
  output logic [N_BTN-1:0]  btn_level,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CODE_W-1:0] evt_code,
  output logic              evt_drop
);

  import game_input_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [N_BTN-1:0]  evt;
  logic [N_BTN-1:0]  pending;
  logic [N_BTN-1:0]  sel_oh;
  logic [N_BTN-1:0]  clear_mask;
  logic [N_BTN-1:0]  merge;
  logic              has_sel;
  logic [CODE_W-1:0] sel_code;
  logic              push;
  logic              pop;
  logic [CODE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_conditioner #(
      .DEBOUNCE      (DEBOUNCE),
      .REPEAT_EN     (REPEAT_MASK[i]),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_cond (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_in[i]),
      .level (btn_level[i]),
      .evt   (evt[i])
    );
  end

  // Handshake: the head entry transfers on any cycle where evt_valid and
  // evt_ready are both high; evt_valid never drops and evt_code never changes
  // until that transfer happens.
  always_comb begin
    has_sel  = 1'b0;
    sel_code = CODE_W'(CODE_IDLE);
    sel_oh   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (pending[i]) begin
        has_sel  = 1'b1;
        sel_code = CODE_W'(btn_code(i));
        sel_oh   = N_BTN'(1) << i;
      end
    end
    // A full FIFO stalls the push even when a pop happens in the same cycle.
    push       = has_sel && (count < CNT_W'(FIFO_DEPTH));
    pop        = (count != '0) && evt_ready;
    clear_mask = push ? sel_oh : '0;
    merge      = evt & pending & ~clear_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      evt_drop <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      pending  <= (pending & ~clear_mask) | evt;
      evt_drop <= |merge;
      if (push) begin
        mem[wr_ptr] <= sel_code;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!push && pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign evt_valid = (count != '0);
  assign evt_code  = evt_valid ? mem[rd_ptr] : CODE_W'(CODE_IDLE);

endmodule

// File: tb/tb_button_event_queue.sv
// Bench for button_event_queue with short debounce/repeat timings: a vector
// table, hand-written timing sequences and a randomized run against a model.
module tb_button_event_queue;

  localparam int N_BTN         = 7;
  localparam int CODE_W        = 3;
  localparam int DEBOUNCE      = 4;
  localparam int REPEAT_DELAY  = 20;
  localparam int REPEAT_PERIOD = 8;
  localparam int FIFO_DEPTH    = 4;
  localparam logic [N_BTN-1:0] RPT_MASK = 7'b0001111;

  typedef struct {
    int btn;
    int hold;
    int exp_n;
    int exp_code;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N_BTN-1:0]  btn_in = '0;
  logic [N_BTN-1:0]  btn_level;
  logic              evt_valid;
  logic              evt_ready = 1'b1;
  logic [CODE_W-1:0] evt_code;
  logic              evt_drop;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int drop_cnt = 0;

  logic [CODE_W-1:0] obs_code[$];
  int                obs_cyc[$];
  logic [CODE_W-1:0] exp_q[$];

  int   rpt_off[5] = '{20, 28, 36, 44, 52};
  vec_t vecs[9];
  int   base, dbase, e, changes, lvl_seen, b, hold, g, len;

  button_event_queue #(
    .N_BTN         (N_BTN),
    .CODE_W        (CODE_W),
    .DEBOUNCE      (DEBOUNCE),
    .REPEAT_MASK   (RPT_MASK),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD),
    .FIFO_DEPTH    (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_drop  (evt_drop)
  );

  // Clock and cycle stamp.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observer: every completed handshake and every drop pulse.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      obs_code.push_back(evt_code);
      obs_cyc.push_back(cyc);
    end
    if (evt_drop) drop_cnt <= drop_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rnd_tick(input int n);
    repeat (n) begin
      evt_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
  endtask

  task automatic press(input int idx, input int cycles);
    btn_in[idx] = 1'b1;
    tick(cycles);
    btn_in[idx] = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{3, 10, 1, 4};
    vecs[1] = '{0,  3, 0, 0};
    vecs[2] = '{2,  2, 0, 0};
    vecs[3] = '{6, 25, 1, 7};
    vecs[4] = '{0, 21, 2, 1};
    vecs[5] = '{3, 20, 1, 4};
    vecs[6] = '{1, 29, 3, 2};
    vecs[7] = '{4, 60, 1, 5};
    vecs[8] = '{2, 37, 4, 3};

    // Reset state
    tick(3);
    check("rst_valid", evt_valid, 0);
    check("rst_code", evt_code, 0);
    check("rst_level", btn_level, 0);
    check("rst_drop", evt_drop, 0);
    rst = 1'b0;
    tick(2);

    // Single press latency: level after edge 5, one-cycle valid after edge 7
    btn_in[3] = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick(1);
      e = t - 1;
      if (e == 4) check("press_level_pre", btn_level[3], 0);
      if (e == 5) check("press_level", btn_level[3], 1);
      if (e == 6 || e == 8) check($sformatf("press_valid_e%0d", e), evt_valid, 0);
      if (e == 7) begin
        check("press_valid", evt_valid, 1);
        check("press_code", evt_code, 4);
      end
    end
    btn_in[3] = 1'b0;
    tick(12);

    // Glitch of 3 cycles
    base = obs_code.size();
    lvl_seen = 0;
    btn_in[0] = 1'b1;
    for (int t = 0; t < 18; t++) begin
      if (t == 3) btn_in[0] = 1'b0;
      tick(1);
      lvl_seen = lvl_seen | int'(btn_level[0]);
    end
    check("glitch_level", lvl_seen, 0);
    check("glitch_events", obs_code.size() - base, 0);

    // Simultaneous press on 0 and 6
    base = obs_code.size();
    btn_in[0] = 1'b1;
    btn_in[6] = 1'b1;
    tick(12);
    btn_in = '0;
    tick(12);
    check("simul_count", obs_code.size() - base, 2);
    if (obs_code.size() - base == 2) begin
      check("simul_first", obs_code[base], 7);
      check("simul_second", obs_code[base+1], 1);
      check("simul_gap", obs_cyc[base+1] - obs_cyc[base], 1);
    end

    // Auto-repeat on a direction key, none on a reset key
    base = obs_code.size();
    press(1, 60);
    tick(40);
    check("rpt_count", obs_code.size() - base, 6);
    if (obs_code.size() - base == 6) begin
      for (int k = 0; k < 6; k++) check($sformatf("rpt_code%0d", k), obs_code[base+k], 2);
      for (int k = 0; k < 5; k++)
        check($sformatf("rpt_off%0d", k), obs_cyc[base+k+1] - obs_cyc[base], rpt_off[k]);
    end
    base = obs_code.size();
    press(5, 60);
    tick(40);
    check("norpt_count", obs_code.size() - base, 1);
    if (obs_code.size() - base == 1) check("norpt_code", obs_code[base], 6);

    // Backpressure, merge and drain order
    evt_ready = 1'b0;
    dbase = drop_cnt;
    for (int k = 0; k < 5; k++) begin
      press(k, 8);
      tick(8);
    end
    check("bp_valid", evt_valid, 1);
    check("bp_head", evt_code, 1);
    changes = 0;
    btn_in[4] = 1'b1;
    for (int t = 0; t < 18; t++) begin
      if (t == 8) btn_in[4] = 1'b0;
      tick(1);
      if (evt_code != 3'd1 || !evt_valid) changes++;
    end
    check("bp_head_stable", changes, 0);
    check("bp_drop", drop_cnt - dbase, 1);
    base = obs_code.size();
    evt_ready = 1'b1;
    tick(10);
    check("bp_count", obs_code.size() - base, 5);
    if (obs_code.size() - base == 5)
      for (int k = 0; k < 5; k++) check($sformatf("bp_order%0d", k), obs_code[base+k], k + 1);

    // Reset in the middle of a held repeat key with two queued events
    evt_ready = 1'b0;
    press(0, 8);
    tick(8);
    btn_in[1] = 1'b1;
    tick(14);
    check("mid_queued", evt_valid, 1);
    rst = 1'b1;
    tick(1);
    check("mid_rst_valid", evt_valid, 0);
    check("mid_rst_level", btn_level, 0);
    rst = 1'b0;
    evt_ready = 1'b1;
    base = obs_code.size();
    for (int t = 1; t <= 8; t++) begin
      tick(1);
      if (t == 7) check("mid_valid_pre", evt_valid, 0);
      if (t == 8) begin
        check("mid_valid", evt_valid, 1);
        check("mid_code", evt_code, 2);
      end
    end
    tick(2);
    btn_in[1] = 1'b0;
    tick(15);
    check("mid_one_code", obs_code.size() - base, 1);

    // Vector table
    evt_ready = 1'b1;
    for (int v = 0; v < 9; v++) begin
      base = obs_code.size();
      press(vecs[v].btn, vecs[v].hold);
      tick(30);
      check($sformatf("vec%0d_count", v), obs_code.size() - base, vecs[v].exp_n);
      for (int k = base; k < obs_code.size(); k++)
        check($sformatf("vec%0d_code", v), obs_code[k], vecs[v].exp_code);
    end

    // Randomized presses, glitches and consumer stalls against the model
    base = obs_code.size();
    dbase = drop_cnt;
    for (int r = 0; r < 12; r++) begin
      b = $urandom_range(0, N_BTN - 1);
      hold = $urandom_range(6, 60);
      exp_q.push_back(CODE_W'(b + 1));
      if (RPT_MASK[b])
        for (int off = REPEAT_DELAY; off < hold; off += REPEAT_PERIOD)
          exp_q.push_back(CODE_W'(b + 1));
      btn_in[b] = 1'b1;
      rnd_tick(hold);
      btn_in[b] = 1'b0;
      rnd_tick(8);
      g = $urandom_range(0, N_BTN - 1);
      len = $urandom_range(1, DEBOUNCE - 1);
      btn_in[g] = 1'b1;
      rnd_tick(len);
      btn_in[g] = 1'b0;
      rnd_tick(8);
    end
    evt_ready = 1'b1;
    tick(20);
    check("rnd_count", obs_code.size() - base, exp_q.size());
    for (int k = base; k < obs_code.size(); k++)
      if (exp_q.size() > 0) check($sformatf("rnd_code%0d", k - base), obs_code[k], exp_q.pop_front());
    check("rnd_drops", drop_cnt - dbase, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
